// File: rtl/tag_alloc288.sv
// Free-list allocator for 288 tags: availability bitmap, highest-free-first grant,
// one grant and one return per cycle, single-cycle flush.

module ffo_grp #(
    parameter int GW = 16
) (
    input  logic [GW-1:0]         vec_i,
    output logic                  hit_o,
    output logic [$clog2(GW)-1:0] idx_o
);
    // Later iterations overwrite earlier ones, so the highest set bit wins.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = 0; i < GW; i++) begin
            if (vec_i[i]) begin
                hit_o = 1'b1;
                idx_o = i[$clog2(GW)-1:0];
            end
        end
    end
endmodule

module ffo288 (
    input  logic [287:0] vec_i,
    output logic [8:0]   sel_o
);
    localparam int NGRP = 18;
    localparam int GW   = 16;

    logic [NGRP-1:0][GW-1:0] grp_vec;
    logic [NGRP-1:0]         grp_hit;
    logic [NGRP-1:0][3:0]    grp_idx;

    assign grp_vec = vec_i;

    ffo_grp #(.GW(GW)) u_grp [NGRP-1:0] (
        .vec_i (grp_vec),
        .hit_o (grp_hit),
        .idx_o (grp_idx)
    );

    // Upper groups take priority; 511 flags an empty vector.
    always_comb begin
        sel_o = 9'd511;
        for (int g = 0; g < NGRP; g++) begin
            if (grp_hit[g]) begin
                sel_o = {g[4:0], grp_idx[g]};
            end
        end
    end
endmodule

module tag_alloc288 #(
    parameter int NTAG      = 288,
    parameter int LOW_WATER = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush_i,
    input  logic       alloc_req_i,
    output logic       alloc_vld_o,
    output logic [8:0] alloc_tag_o,
    input  logic       free_vld_i,
    input  logic [8:0] free_tag_i,
    output logic [8:0] free_cnt_o,
    output logic       empty_o,
    output logic       low_o,
    output logic       err_o
);
    if (NTAG != 288) begin : g_bad_ntag
        $error("tag_alloc288: NTAG must be 288");
    end

    logic [NTAG-1:0] avail_q, avail_d;
    logic [8:0]      cnt_q, cnt_d;
    logic            vld_q, vld_d;
    logic [8:0]      tag_q, tag_d;
    logic            err_q, err_d;

    logic [8:0]      sel;
    logic            grant;
    logic            free_in_range;
    logic [8:0]      free_idx;
    logic            free_legal;

    ffo288 u_ffo (
        .vec_i (avail_q),
        .sel_o (sel)
    );

    assign grant         = alloc_req_i && (sel != 9'd511);
    assign free_in_range = free_tag_i < 9'(NTAG);
    assign free_idx      = free_in_range ? free_tag_i : 9'd0;
    // A tag being granted this cycle is still marked free, so freeing it is illegal.
    assign free_legal    = free_vld_i && free_in_range && !avail_q[free_idx];

    always_comb begin
        avail_d = avail_q;
        cnt_d   = cnt_q;
        vld_d   = 1'b0;
        tag_d   = tag_q;
        err_d   = 1'b0;
        if (flush_i) begin
            avail_d = '1;
            cnt_d   = 9'(NTAG);
        end else begin
            if (grant) begin
                avail_d[sel] = 1'b0;
                vld_d        = 1'b1;
                tag_d        = sel;
            end
            if (free_legal) begin
                avail_d[free_idx] = 1'b1;
            end
            err_d = free_vld_i && !free_legal;
            case ({grant, free_legal})
                2'b10:   cnt_d = cnt_q - 9'd1;
                2'b01:   cnt_d = cnt_q + 9'd1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            avail_q <= '1;
            cnt_q   <= 9'(NTAG);
            vld_q   <= 1'b0;
            tag_q   <= 9'd0;
            err_q   <= 1'b0;
        end else begin
            avail_q <= avail_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            tag_q   <= tag_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (cnt_q <= 9'(NTAG))
                else $error("tag_alloc288: free count out of range");
            assert ($countones(avail_q) == 32'(cnt_q))
                else $error("tag_alloc288: free count disagrees with bitmap");
        end
    end

    assign alloc_vld_o = vld_q;
    assign alloc_tag_o = tag_q;
    assign free_cnt_o  = cnt_q;
    assign empty_o     = (cnt_q == 9'd0);
    assign low_o       = (cnt_q <= 9'(LOW_WATER));
    assign err_o       = err_q;
endmodule

// File: tb/tb_tag_alloc288.sv
// Scoreboard bench for tag_alloc288: driver pushes per-cycle expectations,
// negedge monitor pops and compares.

module tb_tag_alloc288;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       req = 1'b0;
    logic       fvld = 1'b0;
    logic [8:0] ftag = 9'd0;
    logic       vld_o, empty_o, low_o, err_o;
    logic [8:0] tag_o, cnt_o;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit       vld;
        bit [8:0] tag;
        int       cnt;
        bit       err;
        int       pop;
    } exp_t;

    exp_t       sb[$];
    bit [287:0] m_avail = '1;
    int         m_cnt = 288;
    bit [8:0]   m_tag = 9'd0;

    tag_alloc288 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
        .alloc_req_i (req),
        .alloc_vld_o (vld_o),
        .alloc_tag_o (tag_o),
        .free_vld_i  (fvld),
        .free_tag_i  (ftag),
        .free_cnt_o  (cnt_o),
        .empty_o     (empty_o),
        .low_o       (low_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int hi_free();
        for (int i = 287; i >= 0; i--) if (m_avail[i]) return i;
        return 511;
    endfunction

    function automatic int pick_owned();
        int s = $urandom_range(0, 287);
        for (int k = 0; k < 288; k++) if (!m_avail[(s + k) % 288]) return (s + k) % 288;
        return 300;
    endfunction

    // Apply one cycle of stimulus, predict the post-edge state, and advance.
    task automatic step(input bit r, input bit fv, input int ft, input bit fl, input bit rn);
        exp_t e;
        int   sel;
        bit   g, legal;
        req = r; fvld = fv; ftag = ft[8:0]; flush = fl; rst_n = rn;
        e.vld = 0; e.err = 0;
        if (!rn) begin
            m_avail = '1; m_cnt = 288; m_tag = 9'd0;
        end else if (fl) begin
            m_avail = '1; m_cnt = 288;
        end else begin
            sel   = hi_free();
            g     = r && (sel != 511);
            legal = fv && (ft < 288) && !m_avail[ft];
            if (g) begin m_avail[sel] = 1'b0; m_cnt--; m_tag = sel[8:0]; e.vld = 1; end
            if (legal) begin m_avail[ft] = 1'b1; m_cnt++; end
            e.err = fv && !legal;
        end
        e.tag = m_tag; e.cnt = m_cnt; e.pop = $countones(m_avail);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_vld", int'(vld_o), int'(e.vld));
            if (e.vld) chk("sb_tag", int'(tag_o), int'(e.tag));
            chk("sb_cnt", int'(cnt_o), e.cnt);
            chk("sb_popcount", int'(cnt_o), e.pop);
            chk("sb_empty", int'(empty_o), int'(e.cnt == 0));
            chk("sb_low", int'(low_o), int'(e.cnt <= 8));
            chk("sb_err", int'(err_o), int'(e.err));
        end
    end

    initial begin
        int ft;
        // 1: reset state, then three grants from the top of the pool
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("rst_vld", int'(vld_o), 0);
        chk("rst_cnt", int'(cnt_o), 288);
        chk("rst_tag", int'(tag_o), 0);
        step(1, 0, 0, 0, 1); chk("t1_tag0", int'(tag_o), 287);
        step(1, 0, 0, 0, 1); chk("t1_tag1", int'(tag_o), 286);
        step(1, 0, 0, 0, 1); chk("t1_tag2", int'(tag_o), 285);
        chk("t1_cnt", int'(cnt_o), 285);
        step(0, 0, 0, 0, 1); chk("t1_idle_vld", int'(vld_o), 0);
        chk("t1_hold_tag", int'(tag_o), 285);

        // 2: grant and legal free together, then the freed tag is granted
        step(1, 1, 286, 0, 1);
        chk("t2_tag", int'(tag_o), 284);
        chk("t2_cnt", int'(cnt_o), 285);
        step(1, 0, 0, 0, 1); chk("t2_regrant", int'(tag_o), 286);
        // freeing the tag being granted this cycle is illegal
        step(1, 1, 283, 0, 1);
        chk("t2_same_tag", int'(tag_o), 283);
        chk("t2_same_err", int'(err_o), 1);

        // 3: drain the whole pool
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 288; i++) begin
            step(1, 0, 0, 0, 1);
            if (i == 0)   chk("t3_first", int'(tag_o), 287);
            if (i == 278) chk("t3_low_at9", int'(low_o), 0);
            if (i == 279) chk("t3_low_at8", int'(low_o), 1);
        end
        chk("t3_last", int'(tag_o), 0);
        chk("t3_empty", int'(empty_o), 1);
        step(1, 0, 0, 0, 1);
        chk("t3_289th_vld", int'(vld_o), 0);
        chk("t3_289th_tag", int'(tag_o), 0);

        // 4: illegal frees
        step(0, 0, 0, 0, 0);
        step(0, 1, 100, 0, 1);
        chk("t4_dup_err", int'(err_o), 1);
        chk("t4_dup_cnt", int'(cnt_o), 288);
        step(0, 1, 300, 0, 1);
        chk("t4_range_err", int'(err_o), 1);
        step(0, 0, 0, 0, 1);
        chk("t4_err_clear", int'(err_o), 0);
        step(1, 0, 0, 0, 1);
        chk("t4_top_intact", int'(tag_o), 287);

        // 5: flush overrides a request
        step(0, 0, 0, 0, 0);
        repeat (50) step(1, 0, 0, 0, 1);
        chk("t5_cnt50", int'(cnt_o), 238);
        step(1, 1, 287, 1, 1);
        chk("t5_flush_vld", int'(vld_o), 0);
        chk("t5_flush_cnt", int'(cnt_o), 288);
        chk("t5_flush_err", int'(err_o), 0);
        step(1, 0, 0, 0, 1);
        chk("t5_after", int'(tag_o), 287);

        // 6: reset mid-burst, then random soak
        repeat (5) step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        chk("t6_rst_vld", int'(vld_o), 0);
        chk("t6_rst_cnt", int'(cnt_o), 288);
        for (int i = 0; i < 400; i++) begin
            ft = ($urandom_range(0, 3) != 0) ? pick_owned() : $urandom_range(0, 320);
            step($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, ft,
                 $urandom_range(0, 99) == 0, 1);
        end
        step(0, 0, 0, 0, 1);

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
        #2;
        if (sb.size() > 0) chk("drain_timeout", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
